// File: rtl/pe_bfu_pipe.sv
// Pipelined NTT/INTT butterfly for one lane: the mode travels with each beat, the twiddle is an input.
// Four register stages; when the output is held, every stage holds and in_ready drops.
module pe_bfu_pipe #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int TAG_WIDTH  = 8,
  parameter bit HALVE      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_u,
  input  logic [DATA_WIDTH-1:0] in_v,
  input  logic [DATA_WIDTH-1:0] in_w,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] bf_upper,
  output logic [DATA_WIDTH-1:0] bf_lower,
  output logic                  out_mode,
  output logic [TAG_WIDTH-1:0]  out_tag
);
  localparam int DW = DATA_WIDTH;
  localparam int K  = 2 * DATA_WIDTH;
  localparam longint unsigned MU = (64'd1 << K) / 64'(Q);
  localparam logic [K:0]    MU_L = (K+1)'(MU);
  localparam logic [DW:0]   Q1   = (DW+1)'(Q);
  localparam logic [DW+1:0] Q2   = (DW+2)'(Q);
  localparam logic [K-1:0]  QK   = K'(Q);

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q1) s = s - Q1;
    return s[DW-1:0];
  endfunction

  // A borrow sets the top bit; adding Q modulo 2^(DW+1) lands back in [0, Q).
  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DW]) d = d + Q1;
    return d[DW-1:0];
  endfunction

  // Barrett with k = 2*DW: the quotient estimate is low by at most two, so at most two corrections.
  function automatic logic [DW-1:0] reduce(input logic [K-1:0] x);
    logic [DW-1:0] q;
    logic [DW+1:0] r;
    q = DW'(({{(K+1){1'b0}}, x} * {{K{1'b0}}, MU_L}) >> K);
    r = (DW+2)'(x - {{DW{1'b0}}, q} * QK);
    if (r >= Q2) r = r - Q2;
    if (r >= Q2) r = r - Q2;
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] halve(input logic [DW-1:0] x);
    logic [DW:0] s;
    s = x[0] ? ({1'b0, x} + Q1) : {1'b0, x};
    s = s >> 1;
    return s[DW-1:0];
  endfunction

  logic                 s1_valid, s1_mode;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [DW-1:0]        s1_u, s1_v, s1_w;
  logic                 s2_valid, s2_mode;
  logic [TAG_WIDTH-1:0] s2_tag;
  logic [DW-1:0]        s2_a;
  logic [K-1:0]         s2_p;
  logic                 s3_valid, s3_mode;
  logic [TAG_WIDTH-1:0] s3_tag;
  logic [DW-1:0]        s3_a, s3_r;
  logic                 s4_valid, s4_mode;
  logic [TAG_WIDTH-1:0] s4_tag;
  logic [DW-1:0]        s4_up, s4_lo;

  logic          adv;
  logic [DW-1:0] sum_uv, diff_uv, mul_a, a_sel;
  logic [K-1:0]  prod;
  logic [DW-1:0] nxt_up, nxt_lo;

  assign adv      = !s4_valid || out_ready;
  assign in_ready = adv;

  // INTT subtracts before multiplying, so the twiddle multiplies the difference instead of v.
  assign sum_uv  = mod_add(s1_u, s1_v);
  assign diff_uv = mod_sub(s1_u, s1_v);
  assign mul_a   = s1_mode ? diff_uv : s1_v;
  assign a_sel   = s1_mode ? sum_uv : s1_u;
  assign prod    = {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, s1_w};

  always_comb begin
    nxt_up = mod_add(s3_a, s3_r);
    nxt_lo = mod_sub(s3_a, s3_r);
    if (s3_mode) begin
      nxt_up = HALVE ? halve(s3_a) : s3_a;
      nxt_lo = HALVE ? halve(s3_r) : s3_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_mode <= 1'b0; s1_tag <= '0;
      s1_u     <= '0;   s1_v    <= '0;   s1_w   <= '0;
      s2_valid <= 1'b0; s2_mode <= 1'b0; s2_tag <= '0;
      s2_a     <= '0;   s2_p    <= '0;
      s3_valid <= 1'b0; s3_mode <= 1'b0; s3_tag <= '0;
      s3_a     <= '0;   s3_r    <= '0;
      s4_valid <= 1'b0; s4_mode <= 1'b0; s4_tag <= '0;
      s4_up    <= '0;   s4_lo   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid; s1_mode <= in_mode; s1_tag <= in_tag;
      s1_u     <= in_u;     s1_v    <= in_v;    s1_w   <= in_w;
      s2_valid <= s1_valid; s2_mode <= s1_mode; s2_tag <= s1_tag;
      s2_a     <= a_sel;    s2_p    <= prod;
      s3_valid <= s2_valid; s3_mode <= s2_mode; s3_tag <= s2_tag;
      s3_a     <= s2_a;     s3_r    <= reduce(s2_p);
      s4_valid <= s3_valid; s4_mode <= s3_mode; s4_tag <= s3_tag;
      s4_up    <= nxt_up;   s4_lo   <= nxt_lo;
    end
  end

  assign out_valid = s4_valid;
  assign out_mode  = s4_mode;
  assign out_tag   = s4_tag;
  assign bf_upper  = s4_up;
  assign bf_lower  = s4_lo;
endmodule

// File: tb/tb_pe_bfu_pipe.sv
// Bench for pe_bfu_pipe: two instances (HALVE=0 and HALVE=1) share one input stream and one
// out_ready; a queue holds model results for each accepted beat and is popped on consumption.
module tb_pe_bfu_pipe;
  localparam int DW = 12;
  localparam int Q  = 3329;
  localparam int TW = 8;
  localparam int HINV = (Q + 1) / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_u = '0, in_v = '0, in_w = '0;
  logic [TW-1:0] in_tag = '0;
  logic          rdy0, rdy1, ov0, ov1, om0, om1;
  logic [DW-1:0] up0, lo0, up1, lo1;
  logic [TW-1:0] ot0, ot1;

  pe_bfu_pipe #(.DATA_WIDTH(DW), .Q(Q), .TAG_WIDTH(TW), .HALVE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_mode(in_mode),
    .in_u(in_u), .in_v(in_v), .in_w(in_w), .in_tag(in_tag), .out_valid(ov0),
    .out_ready(out_ready), .bf_upper(up0), .bf_lower(lo0), .out_mode(om0), .out_tag(ot0));

  pe_bfu_pipe #(.DATA_WIDTH(DW), .Q(Q), .TAG_WIDTH(TW), .HALVE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_mode(in_mode),
    .in_u(in_u), .in_v(in_v), .in_w(in_w), .in_tag(in_tag), .out_valid(ov1),
    .out_ready(out_ready), .bf_upper(up1), .bf_lower(lo1), .out_mode(om1), .out_tag(ot1));

  typedef struct {
    int tag; int mode; int u0; int l0; int u1; int l1;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_pass = 0, n_out = 0;
  logic rnd_rdy = 1'b0;
  logic hold = 1'b0;
  logic [DW-1:0] h_up0, h_lo0, h_up1, h_lo1;
  logic [TW-1:0] h_tag;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
  endtask

  // Reference: plain integer arithmetic; halving as multiplication by the inverse of 2.
  task automatic ref_bf(input int u, input int v, input int w, input int m, input int hv,
                        output int up, output int lo);
    int t;
    if (m == 0) begin
      t  = (v * w) % Q;
      up = (u + t) % Q;
      lo = (u - t + Q) % Q;
    end else begin
      up = (u + v) % Q;
      lo = (((u - v + Q) % Q) * w) % Q;
      if (hv != 0) begin
        up = (up * HINV) % Q;
        lo = (lo * HINV) % Q;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      chk("in_ready", rdy0, !ov0 || out_ready);
      chk("valid_pair", ov1, ov0);
      if (in_valid && rdy0) begin
        e.tag = in_tag; e.mode = in_mode;
        ref_bf(in_u, in_v, in_w, in_mode, 0, e.u0, e.l0);
        ref_bf(in_u, in_v, in_w, in_mode, 1, e.u1, e.l1);
        sb.push_back(e);
      end
      if (ov0) begin
        if (hold) begin
          chk("stall_upper0", up0, h_up0); chk("stall_lower0", lo0, h_lo0);
          chk("stall_upper1", up1, h_up1); chk("stall_lower1", lo1, h_lo1);
          chk("stall_tag", ot0, h_tag);
        end
        if (out_ready) begin
          hold = 1'b0;
          chk("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            n_out++;
            chk("tag0", ot0, e.tag);   chk("tag1", ot1, e.tag);
            chk("mode0", om0, e.mode); chk("mode1", om1, e.mode);
            chk("upper_h0", up0, e.u0); chk("lower_h0", lo0, e.l0);
            chk("upper_h1", up1, e.u1); chk("lower_h1", lo1, e.l1);
          end
        end else begin
          hold = 1'b1;
          h_up0 = up0; h_lo0 = lo0; h_up1 = up1; h_lo1 = lo1; h_tag = ot0;
        end
      end
    end
  end

  // Holds the beat until an edge accepts it; returns 1 ns after that edge.
  task automatic send(input int u, input int v, input int w, input int m, input int t);
    int   guard = 0;
    logic acc;
    in_valid = 1'b1; in_u = DW'(u); in_v = DW'(v); in_w = DW'(w);
    in_mode = m[0]; in_tag = TW'(t);
    do begin
      @(negedge clk); acc = rdy0;
      @(posedge clk); #1; guard++;
    end while (!acc && guard < 1000);
    chk("send_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic one_beat(input int u, input int v, input int w, input int m, input int t,
                          input int eu0, input int el0, input int eu1, input int el1,
                          input string nm);
    int lat = 0;
    send(u, v, w, m, t);
    while (!ov0 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_upper_h0"}, up0, eu0); chk({nm, "_lower_h0"}, lo0, el0);
    chk({nm, "_upper_h1"}, up1, eu1); chk({nm, "_lower_h1"}, lo1, el1);
    chk({nm, "_tag"}, ot0, t);
  endtask

  initial begin
    int cyc, sent, n0;
    #1;
    chk("rst_valid0", ov0, 0); chk("rst_valid1", ov1, 0);
    chk("rst_upper", up0, 0);  chk("rst_lower", lo0, 0);
    chk("rst_tag", ot0, 0);    chk("rst_mode", om0, 0);
    #20 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", rdy0, 1);

    one_beat(1, 2, 17, 0, 100, 35, 3296, 35, 3296, "ntt_basic");
    one_beat(3328, 3328, 3328, 0, 101, 0, 3327, 0, 3327, "ntt_wrap");
    one_beat(5, 3, 17, 1, 102, 8, 34, 4, 17, "intt");
    one_beat(0, 1, 1, 1, 103, 1, 3328, 1665, 1664, "intt_odd");
    drain();

    // Full-rate stream: 16 beats present on the output within 19 edges.
    cyc = 0; sent = 0; n0 = n_out;
    in_valid = 1'b1; in_tag = '0; in_mode = 1'b0;
    in_u = DW'($urandom_range(0, Q-1)); in_v = DW'($urandom_range(0, Q-1));
    in_w = DW'($urandom_range(0, Q-1));
    while (!(ov0 && ot0 == 8'd15) && cyc < 100) begin
      @(posedge clk); #1; cyc++; sent++;
      if (sent < 16) begin
        in_tag = TW'(sent); in_mode = sent[0];
        in_u = DW'($urandom_range(0, Q-1)); in_v = DW'($urandom_range(0, Q-1));
        in_w = DW'($urandom_range(0, Q-1));
      end else in_valid = 1'b0;
    end
    chk("throughput_cycles", cyc, 19);
    drain();
    chk("throughput_count", n_out - n0, 16);

    // Backpressure: 16 mixed beats with out_ready toggling.
    @(posedge clk); #3; rnd_rdy = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 16; i++)
      send($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
           $urandom_range(0, 1), i);
    drain();
    chk("bp_count", n_out - n0, 16);
    @(posedge clk); #3; rnd_rdy = 1'b0; out_ready = 1'b1;

    // Reset with three beats in flight, the oldest on the output.
    drain();
    send(7, 8, 9, 0, 200);
    send(10, 11, 12, 1, 201);
    send(13, 14, 15, 0, 202);
    @(posedge clk); #1;
    chk("pre_rst_valid", ov0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid0", ov0, 0); chk("mid_rst_valid1", ov1, 0);
    chk("mid_rst_upper0", up0, 0); chk("mid_rst_lower0", lo0, 0);
    chk("mid_rst_upper1", up1, 0); chk("mid_rst_lower1", lo1, 0);
    chk("mid_rst_tag", ot0, 0);    chk("mid_rst_mode", om1, 0);
    sb.delete();
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("ready_after_mid_rst", rdy0, 1);
    one_beat(5, 3, 17, 1, 55, 8, 34, 4, 17, "post_rst");
    drain();

    // Randomised sweep, mixed modes, random stalls; both HALVE settings at once.
    @(posedge clk); #3; rnd_rdy = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 6000; i++)
      send($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
           $urandom_range(0, 1), i % 256);
    drain();
    chk("sweep_count", n_out - n0, 6000);
    @(posedge clk); #3; rnd_rdy = 1'b0; out_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
